// File: rtl/color_fsm_driver.sv
// color_fsm_driver
//
// Steers a two-state Color Moore FSM (Blue/Red) to a requested colour.
// Each request reads the peer's current colour. If the colour differs from
// the target, the driver toggles the peer with single-cycle kicks. After each
// kick it waits up to SETTLE cycles for the new colour to show up, and it
// gives up after MAX_RETRY kicks. The outcome is returned through a
// valid/ready completion channel.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   req_valid    request present
//   req_ready    driver idle and able to accept a request
//   req_target   requested colour: 0 = Blue, 1 = Red
//   fsm_in       drives the peer's `in` bus (2'h2 hold, 2'h1 kick/toggle)
//   fsm_out      peer's `out` bus (2'h1 Blue, 2'h2 Red, other values illegal)
//   done_valid   completion present
//   done_ready   consumer accepts the completion
//   done_status  2'b00 OK, 2'b01 TIMEOUT, 2'b10 BAD_ENC
//   done_kicks   number of kicks issued for this request

module color_fsm_driver #(
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_target,
  output logic [1:0]       fsm_in,
  input  logic [1:0]       fsm_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [1:0]       done_status,
  output logic [CNT_W-1:0] done_kicks
);

  localparam logic [1:0] IN_KICK = 2'h1;
  localparam logic [1:0] IN_HOLD = 2'h2;

  localparam logic [1:0] OUT_BLUE = 2'h1;
  localparam logic [1:0] OUT_RED  = 2'h2;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BAD_ENC = 2'b10;

  localparam logic [CNT_W-1:0] SETTLE_C    = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] MAX_RETRY_C = CNT_W'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  // Parameter sanity checks, evaluated at elaboration.
  generate
    if (MAX_RETRY < 1 || MAX_RETRY >= (1 << CNT_W)) begin : g_bad_max_retry
      $error("color_fsm_driver: MAX_RETRY must be in [1, 2**CNT_W - 1]");
    end
    if (SETTLE < 1 || SETTLE >= (1 << CNT_W)) begin : g_bad_settle
      $error("color_fsm_driver: SETTLE must be in [1, 2**CNT_W - 1]");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_KICK,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic             target_q, target_d;
  logic [CNT_W-1:0] kicks_q, kicks_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [1:0]       fsm_in_q, fsm_in_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] done_kicks_q, done_kicks_d;

  logic       out_legal;
  logic       out_match;
  logic [1:0] target_code;

  assign target_code = target_q ? OUT_RED : OUT_BLUE;
  assign out_legal   = (fsm_out == OUT_BLUE) || (fsm_out == OUT_RED);
  assign out_match   = (fsm_out == target_code);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= 1'b0;
      kicks_q      <= '0;
      settle_q     <= '0;
      fsm_in_q     <= IN_HOLD;
      status_q     <= ST_OK;
      done_kicks_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      kicks_q      <= kicks_d;
      settle_q     <= settle_d;
      fsm_in_q     <= fsm_in_d;
      status_q     <= status_d;
      done_kicks_q <= done_kicks_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    kicks_d      = kicks_q;
    settle_d     = settle_q;
    status_d     = status_q;
    done_kicks_d = done_kicks_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          target_d = req_target;
          kicks_d  = '0;
          settle_d = '0;
          state_d  = S_CHECK;
        end
      end

      S_CHECK: begin
        // The illegal-encoding test comes first, so a stuck bus is never
        // mistaken for a colour.
        if (!out_legal) begin
          status_d     = ST_BAD_ENC;
          done_kicks_d = kicks_q;
          state_d      = S_RESP;
        end else if (out_match) begin
          status_d     = ST_OK;
          done_kicks_d = '0;
          state_d      = S_RESP;
        end else begin
          state_d = S_KICK;
        end
      end

      S_KICK: begin
        kicks_d  = (kicks_q == CNT_MAX) ? kicks_q : kicks_q + 1'b1;
        settle_d = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (!out_legal) begin
          status_d     = ST_BAD_ENC;
          done_kicks_d = kicks_q;
          state_d      = S_RESP;
        end else if (out_match) begin
          status_d     = ST_OK;
          done_kicks_d = kicks_q;
          state_d      = S_RESP;
        end else begin
          settle_d = settle_q + 1'b1;
          if (settle_d == SETTLE_C) begin
            if (kicks_q < MAX_RETRY_C) begin
              state_d = S_KICK;
            end else begin
              status_d     = ST_TIMEOUT;
              done_kicks_d = kicks_q;
              state_d      = S_RESP;
            end
          end
        end
      end

      S_RESP: begin
        if (done_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // fsm_in is registered from the next state. The kick code therefore
    // appears in exactly the cycle in which the FSM sits in KICK. It comes
    // straight from a flop, so it cannot glitch.
    fsm_in_d = (state_d == S_KICK) ? IN_KICK : IN_HOLD;
  end

  assign req_ready   = (state_q == S_IDLE);
  assign done_valid  = (state_q == S_RESP);
  assign fsm_in      = fsm_in_q;
  assign done_status = status_q;
  assign done_kicks  = done_kicks_q;

endmodule
